pcecd_scsi_target: RTL

- Parametrised SCSI target phase engine for the PC Engine CD interface.
- Replaces the fixed, command-only phase logic with a full target sequencer: BUS_FREE → COMMAND → EXEC → DATA_IN → STATUS → MESSAGE_IN → BUS_FREE.
- Command length is decoded from the opcode group.
- Sits between the $1800–$1804 register front end (initiator side) and the drive/host model that executes commands and supplies data, status and message bytes.

---
 rtl/pcecd_scsi_target.sv | 311 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/pcecd_scsi_target.sv
// PC Engine CD SCSI target phase engine.
// Sequences BUS_FREE -> COMMAND -> EXEC -> DATA_IN -> STATUS -> MESSAGE_IN -> BUS_FREE
// and runs the REQ/ACK handshake towards the initiator-side register front end.
// Command length comes from the opcode group. The host model supplies data, status and message.
module pcecd_scsi_target #(
    parameter int CMD_DEPTH = 12,
    parameter int CNT_W     = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_sel,
    input  logic                   i_ack,
    input  logic                   i_bus_rst,
    input  logic [7:0]             i_db,
    output logic [7:0]             o_db,
    output logic                   o_bsy,
    output logic                   o_req,
    output logic                   o_msg,
    output logic                   o_cd,
    output logic                   o_io,
    output logic [2:0]             o_phase,
    output logic                   o_cmd_valid,
    input  logic                   i_cmd_ready,
    output logic [CMD_DEPTH*8-1:0] o_cmd_data,
    output logic [3:0]             o_cmd_len,
    input  logic                   i_din_valid,
    input  logic [7:0]             i_din_data,
    output logic                   o_din_ready,
    input  logic                   i_status_valid,
    input  logic [7:0]             i_status,
    input  logic [7:0]             i_message,
    output logic [CNT_W-1:0]       o_din_count,
    output logic                   o_irq_ready,
    output logic                   o_irq_done
);

    typedef enum logic [2:0] {
        PH_FREE = 3'd0,
        PH_CMD  = 3'd1,
        PH_EXEC = 3'd2,
        PH_DIN  = 3'd3,
        PH_STAT = 3'd4,
        PH_MSG  = 3'd5
    } phase_e;

    // Command length from opcode group (bits 7:5).
    function automatic logic [3:0] decode_len(input logic [7:0] op);
        case (op[7:5])
            3'd0:       decode_len = 4'd6;
            3'd1, 3'd2: decode_len = 4'd10;
            3'd5:       decode_len = 4'd12;
            default:    decode_len = 4'd6;
        endcase
    endfunction

    // Target bus signals for a phase, packed as {bsy, msg, cd, io}.
    function automatic logic [3:0] bus_of(input phase_e ph);
        case (ph)
            PH_FREE: bus_of = 4'b0000;
            PH_CMD:  bus_of = 4'b1010;
            PH_EXEC: bus_of = 4'b1000;
            PH_DIN:  bus_of = 4'b1001;
            PH_STAT: bus_of = 4'b1011;
            PH_MSG:  bus_of = 4'b1111;
            default: bus_of = 4'b0000;
        endcase
    endfunction

    phase_e                 phase_r, phase_nx_s;
    logic                   rst_s;
    logic                   req_r, req_nx_s;
    logic                   wait_r, wait_nx_s;       // REQ has fallen, waiting for ACK release
    logic [3:0]             pos_r, pos_nx_s;
    logic [3:0]             len_r, len_nx_s;
    logic [CMD_DEPTH*8-1:0] cmd_data_r, cmd_data_nx_s;
    logic                   cmd_valid_r, cmd_valid_nx_s;
    logic [CNT_W-1:0]       cnt_r, cnt_nx_s;
    logic [7:0]             stat_r, stat_nx_s;
    logic [7:0]             msg_r, msg_nx_s;
    logic [7:0]             db_r, db_nx_s;
    logic                   din_ready_nx_s, din_ready_r;
    logic                   irq_ready_nx_s, irq_ready_r;
    logic                   irq_done_nx_s, irq_done_r;
    logic [3:0]             bus_r;
    logic                   req_fall_s;
    logic                   idle_s;
    logic                   done_s;
    logic [3:0]             last_pos_s;

    assign rst_s      = i_rst | i_bus_rst;
    assign req_fall_s = req_r & i_ack;
    assign idle_s     = ~req_r & ~i_ack;
    assign done_s     = idle_s & wait_r;
    assign last_pos_s = len_r - 4'd1;

    // Phase state register.
    always_ff @(posedge i_clk) begin
        if (rst_s) begin
            phase_r <= PH_FREE;
        end else begin
            phase_r <= phase_nx_s;
        end
    end

    // Phase transitions.
    always_comb begin
        phase_nx_s = phase_r;
        case (phase_r)
            PH_FREE: begin
                if (i_sel && !i_ack) phase_nx_s = PH_CMD;
                else                 phase_nx_s = PH_FREE;
            end
            PH_CMD: begin
                if (done_s && (pos_r == last_pos_s)) phase_nx_s = PH_EXEC;
                else                                 phase_nx_s = PH_CMD;
            end
            PH_EXEC: begin
                if (cmd_valid_r && i_cmd_ready) phase_nx_s = PH_DIN;
                else                            phase_nx_s = PH_EXEC;
            end
            PH_DIN: begin
                // Data wins over status when both are offered.
                if (idle_s && !i_din_valid && i_status_valid) phase_nx_s = PH_STAT;
                else                                          phase_nx_s = PH_DIN;
            end
            PH_STAT: begin
                if (done_s) phase_nx_s = PH_MSG;
                else        phase_nx_s = PH_STAT;
            end
            PH_MSG: begin
                if (done_s) phase_nx_s = PH_FREE;
                else        phase_nx_s = PH_MSG;
            end
            default: phase_nx_s = PH_FREE;
        endcase
    end

    // Handshake, buffer, counter and pulse next values.
    always_comb begin
        req_nx_s       = req_r;
        wait_nx_s      = wait_r;
        pos_nx_s       = pos_r;
        len_nx_s       = len_r;
        cmd_data_nx_s  = cmd_data_r;
        cmd_valid_nx_s = cmd_valid_r;
        cnt_nx_s       = cnt_r;
        stat_nx_s      = stat_r;
        msg_nx_s       = msg_r;
        db_nx_s        = db_r;
        din_ready_nx_s = 1'b0;
        irq_ready_nx_s = 1'b0;
        irq_done_nx_s  = 1'b0;

        // ACK seen while REQ is high: drop REQ and wait for ACK release.
        if (req_fall_s) begin
            req_nx_s  = 1'b0;
            wait_nx_s = 1'b1;
        end else begin
            req_nx_s  = req_r;
        end

        case (phase_r)
            PH_FREE: begin
                if (i_sel && !i_ack) begin
                    req_nx_s      = 1'b1;
                    wait_nx_s     = 1'b0;
                    pos_nx_s      = 4'd0;
                    len_nx_s      = 4'd0;
                    cmd_data_nx_s = '0;
                    db_nx_s       = 8'd0;
                end else begin
                    req_nx_s      = 1'b0;
                end
            end
            PH_CMD: begin
                if (req_fall_s) begin
                    // Bytes past the buffer are handshaken but dropped.
                    for (int i = 0; i < CMD_DEPTH; i++) begin
                        if (int'(pos_r) == i) cmd_data_nx_s[i*8 +: 8] = i_db;
                        else                  cmd_data_nx_s[i*8 +: 8] = cmd_data_r[i*8 +: 8];
                    end
                    if (pos_r == 4'd0) len_nx_s = decode_len(i_db);
                    else               len_nx_s = len_r;
                end else if (done_s) begin
                    wait_nx_s = 1'b0;
                    if (pos_r == last_pos_s) begin
                        req_nx_s       = 1'b0;
                        cmd_valid_nx_s = 1'b1;
                    end else begin
                        pos_nx_s = pos_r + 4'd1;
                        req_nx_s = 1'b1;
                    end
                end else begin
                    pos_nx_s = pos_r;
                end
            end
            PH_EXEC: begin
                if (cmd_valid_r && i_cmd_ready) begin
                    cmd_valid_nx_s = 1'b0;
                    cnt_nx_s       = '0;
                end else begin
                    cmd_valid_nx_s = cmd_valid_r;
                end
            end
            PH_DIN: begin
                if (idle_s) begin
                    if (wait_r) begin
                        wait_nx_s = 1'b0;
                        if (&cnt_r) cnt_nx_s = cnt_r;
                        else        cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        wait_nx_s = 1'b0;
                    end
                    if (i_din_valid) begin
                        din_ready_nx_s = 1'b1;
                        db_nx_s        = i_din_data;
                        req_nx_s       = 1'b1;
                    end else if (i_status_valid) begin
                        irq_ready_nx_s = 1'b1;
                        stat_nx_s      = i_status;
                        msg_nx_s       = i_message;
                    end else begin
                        req_nx_s       = 1'b0;
                    end
                end else begin
                    db_nx_s = db_r;
                end
            end
            PH_STAT: begin
                if (idle_s) begin
                    if (wait_r) begin
                        wait_nx_s = 1'b0;
                    end else begin
                        db_nx_s  = stat_r;
                        req_nx_s = 1'b1;
                    end
                end else begin
                    db_nx_s = db_r;
                end
            end
            PH_MSG: begin
                if (idle_s) begin
                    if (wait_r) begin
                        wait_nx_s     = 1'b0;
                        irq_done_nx_s = 1'b1;
                    end else begin
                        db_nx_s  = msg_r;
                        req_nx_s = 1'b1;
                    end
                end else begin
                    db_nx_s = db_r;
                end
            end
            default: begin
                req_nx_s  = 1'b0;
                wait_nx_s = 1'b0;
            end
        endcase
    end

    // Registered datapath and bus outputs; either reset source clears everything.
    always_ff @(posedge i_clk) begin
        if (rst_s) begin
            req_r       <= 1'b0;
            wait_r      <= 1'b0;
            pos_r       <= 4'd0;
            len_r       <= 4'd0;
            cmd_data_r  <= '0;
            cmd_valid_r <= 1'b0;
            cnt_r       <= '0;
            stat_r      <= 8'd0;
            msg_r       <= 8'd0;
            db_r        <= 8'd0;
            din_ready_r <= 1'b0;
            irq_ready_r <= 1'b0;
            irq_done_r  <= 1'b0;
            bus_r       <= 4'd0;
        end else begin
            req_r       <= req_nx_s;
            wait_r      <= wait_nx_s;
            pos_r       <= pos_nx_s;
            len_r       <= len_nx_s;
            cmd_data_r  <= cmd_data_nx_s;
            cmd_valid_r <= cmd_valid_nx_s;
            cnt_r       <= cnt_nx_s;
            stat_r      <= stat_nx_s;
            msg_r       <= msg_nx_s;
            db_r        <= db_nx_s;
            din_ready_r <= din_ready_nx_s;
            irq_ready_r <= irq_ready_nx_s;
            irq_done_r  <= irq_done_nx_s;
            bus_r       <= bus_of(phase_nx_s);
        end
    end

    assign o_db        = db_r;
    assign o_req       = req_r;
    assign o_bsy       = bus_r[3];
    assign o_msg       = bus_r[2];
    assign o_cd        = bus_r[1];
    assign o_io        = bus_r[0];
    assign o_phase     = phase_r;
    assign o_cmd_valid = cmd_valid_r;
    assign o_cmd_data  = cmd_data_r;
    assign o_cmd_len   = len_r;
    assign o_din_ready = din_ready_r;
    assign o_din_count = cnt_r;
    assign o_irq_ready = irq_ready_r;
    assign o_irq_done  = irq_done_r;

endmodule
